mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WORD, default 64: datapath width; the design is fixed at 64 bits with 8 byte lanes.
REQ-002 Parameter TIMEOUT, default 15: maximum REQ-state cycles without bus_ack before an error completion.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 mem_read  input  1  load request; sampled with start.
REQ-007 mem_write  input  1  store request; sampled with start.
REQ-008 size  input  2  access size: 0=byte, 1=half, 2=word, 3=doubleword.
REQ-009 address  input  WORD  byte address, from the ALU result.
REQ-010 write_data  input  WORD  store data, right-justified.
REQ-011 read_data  output  WORD  load result, right-justified, upper bits zero; feeds writeback.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 error  output  1  qualifies done; high only together with done.
REQ-015 bus_req  output  1  memory request; held until acknowledged.
REQ-016 bus_we  output  1  1=write, 0=read; valid while bus_req is high.
REQ-017 bus_addr  output  WORD  doubleword-aligned address: {address[63:3], 3'b000}.
REQ-018 bus_wdata  output  WORD  store data shifted to its byte lanes.
REQ-019 bus_wstrb  output  8  byte-lane enables; all zero on reads.
REQ-020 bus_rdata  input  WORD  memory read data; valid with bus_ack.
REQ-021 bus_ack  input  1  memory completion; honoured only in REQ.

Function
REQ-022 FSM states: IDLE, REQ, RESP.
REQ-023 In IDLE, start=1 latches address, size, write_data, mem_read and mem_write into internal registers.
REQ-024 IDLE transitions on start:
- exactly one of mem_read/mem_write set, address aligned -> REQ;
- otherwise -> RESP.
REQ-025 Alignment is required per size: half requires address[0]=0, word requires address[1:0]=0, doubleword requires address[2:0]=0.
REQ-026 Completions that bypass the bus (no bus_req is ever raised):
- misaligned address -> error=1;
- both mem_read and mem_write set -> error=1;
- neither set -> error=0 (no-op).
REQ-027 In REQ the outputs are driven as follows:
- bus_req=1;
- offset = address[2:0];
- bus_wdata = write_data << (8*offset);
- bus_wstrb = size mask (0x01, 0x03, 0x0F, 0xFF) << offset on writes, 0 on reads.
REQ-028 REQ with bus_ack=1 -> RESP on the next edge; on reads, read_data <= (bus_rdata >> 8*offset) masked to the access size.
REQ-029 Timeout counter (4 bits) clears on REQ entry and increments for each REQ cycle without bus_ack; when it reaches TIMEOUT without an ack -> RESP with error=1, and read_data is unchanged.
REQ-030 bus_req deasserts on the edge that leaves REQ, so it is never high in IDLE or RESP.
REQ-031 RESP lasts exactly one cycle with done=1 (and error per REQ-026/REQ-029), then returns to IDLE.
REQ-032 Latency, with start in cycle 0:
- bus completion: done in cycle N+1, where N is the cycle bus_ack is seen (N>=1);
- bypass completion: done in cycle 1.
REQ-033 start while busy=1 is ignored, not queued.
REQ-034 bus_ack outside REQ is ignored.
REQ-035 read_data holds its value until the next successful read; writes and errors leave it unchanged.
REQ-036 A bus_ack arriving in the same cycle the counter reaches TIMEOUT counts as success.

Reset
REQ-037 When reset=1, on the next edge: state=IDLE, counter=0, and all outputs 0 (read_data, busy, done, error, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb).
REQ-038 Reset mid-transaction (REQ or RESP) aborts without raising done; bus_req is low from the following cycle.

Verification
REQ-039 LDURB: mem_read, size=0, address=0x1003, bus_ack in cycle 1 with bus_rdata=0x8877665544332211 -> bus_addr=0x1000, read_data=0x44, done in cycle 2.
REQ-040 STURH: mem_write, size=1, address=0x2006, write_data=0xBEEF -> bus_wstrb=0xC0, bus_wdata=0xBEEF000000000000, bus_we=1.
REQ-041 Misaligned word load at address 0x1002 -> done=error=1 in cycle 1, bus_req never asserted.
REQ-042 bus_ack never asserted -> done=error=1 after 15 REQ cycles, bus_req drops, read_data unchanged.
REQ-043 reset asserted in cycle 3 of a pending read -> IDLE, all outputs 0, no done; a new start completes normally.
REQ-044 start pulsed while busy, ack after 3 cycles -> exactly one done pulse, no second transaction.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the pipeline to a 64-bit byte-strobed memory bus.
// Handles alignment checks, byte-lane steering, load extraction and a bus timeout.
module mem_access_unit #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic [WORD-1:0]   address,
    input  logic [WORD-1:0]   write_data,
    output logic [WORD-1:0]   read_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD-1:0]   bus_addr,
    output logic [WORD-1:0]   bus_wdata,
    output logic [7:0]        bus_wstrb,
    input  logic [WORD-1:0]   bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic              we_q;
    logic [WORD-1:0]   read_data_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [WORD-1:0]   bus_addr_q;
    logic [WORD-1:0]   bus_wdata_q;
    logic [7:0]        bus_wstrb_q;

    logic [2:0]        off_d;
    logic [7:0]        size_mask;
    logic              misaligned;
    logic              go_bus;
    logic              bypass_err;
    logic [7:0]        bus_wstrb_d;
    logic [WORD-1:0]   bus_wdata_d;
    logic [WORD-1:0]   rd_shift;
    logic [WORD-1:0]   read_data_d;

    always_comb begin
        off_d     = address[2:0];
        size_mask = 8'h01;
        misaligned = 1'b0;
        case (size)
            2'd0: begin size_mask = 8'h01; misaligned = 1'b0;            end
            2'd1: begin size_mask = 8'h03; misaligned = address[0];      end
            2'd2: begin size_mask = 8'h0F; misaligned = |address[1:0];   end
            default: begin size_mask = 8'hFF; misaligned = |address[2:0]; end
        endcase
        go_bus      = (mem_read ^ mem_write) & ~misaligned;
        // A no-op (neither read nor write) completes cleanly even if misaligned.
        bypass_err  = (mem_read & mem_write) | ((mem_read | mem_write) & misaligned);
        bus_wstrb_d = mem_write ? (size_mask << off_d) : 8'h00;
        bus_wdata_d = write_data << {off_d, 3'b000};
    end

    always_comb begin
        rd_shift    = bus_rdata >> {off_q, 3'b000};
        read_data_d = rd_shift;
        case (size_q)
            2'd0:    read_data_d = {56'd0, rd_shift[7:0]};
            2'd1:    read_data_d = {48'd0, rd_shift[15:0]};
            2'd2:    read_data_d = {32'd0, rd_shift[31:0]};
            default: read_data_d = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            size_q      <= 2'd0;
            off_q       <= 3'd0;
            we_q        <= 1'b0;
            read_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= 8'h00;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        size_q <= size;
                        off_q  <= off_d;
                        we_q   <= mem_write;
                        busy_q <= 1'b1;
                        if (go_bus) begin
                            state_q     <= S_REQ;
                            cnt_q       <= 4'd0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mem_write;
                            bus_addr_q  <= {address[WORD-1:3], 3'b000};
                            bus_wdata_q <= bus_wdata_d;
                            bus_wstrb_q <= bus_wstrb_d;
                        end else begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            error_q <= bypass_err;
                        end
                    end
                end
                S_REQ: begin
                    // An ack on the final allowed cycle wins over the timeout.
                    if (bus_ack || (cnt_q == 4'(TIMEOUT - 1))) begin
                        state_q     <= S_RESP;
                        done_q      <= 1'b1;
                        error_q     <= ~bus_ack;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= '0;
                        bus_wdata_q <= '0;
                        bus_wstrb_q <= 8'h00;
                        if (bus_ack && !we_q) begin
                            read_data_q <= read_data_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign read_data = read_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random transactions against a
// transaction-level model of alignment, lane steering, latency and timeout.
module tb_mem_access_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic [63:0] address;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic [63:0] bus_rdata;
    logic        bus_ack;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [63:0] exp_rdata;

    mem_access_unit #(.WORD(64), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, read_data, 64'd0);
        chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
        chk({tag, "_done"},  {63'd0, done}, 64'd0);
        chk({tag, "_err"},   {63'd0, error}, 64'd0);
        chk({tag, "_breq"},  {63'd0, bus_req}, 64'd0);
        chk({tag, "_bwe"},   {63'd0, bus_we}, 64'd0);
        chk({tag, "_baddr"}, bus_addr, 64'd0);
        chk({tag, "_bwdat"}, bus_wdata, 64'd0);
        chk({tag, "_bstrb"}, {56'd0, bus_wstrb}, 64'd0);
    endtask

    // ack_at: REQ cycle (counting start as cycle 0) in which bus_ack is driven; 0 = never.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int ack_at, input bit poke_busy);
        int          bytes;
        int          off;
        bit          misal;
        bit          bypass;
        bit          exp_err;
        bit          ack_ok;
        int          exp_done_cyc;
        int          cyc;
        logic [63:0] exp_wdata;
        logic [63:0] exp_addr;
        logic [63:0] szmask;
        logic [7:0]  exp_strb;

        bytes   = 1 << sz;
        off     = int'(addr[2:0]);
        misal   = (off % bytes) != 0;
        bypass  = (rd == wr) || misal;
        exp_err = (rd && wr) || ((rd != wr) && misal);

        start = 1'b1; mem_read = rd; mem_write = wr; size = sz;
        address = addr; write_data = wdata;
        step();
        start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = {$urandom, $urandom}; write_data = {$urandom, $urandom};

        if (bypass) begin
            chk("byp_done", {63'd0, done}, 64'd1);
            chk("byp_err", {63'd0, error}, {63'd0, exp_err});
            chk("byp_busy", {63'd0, busy}, 64'd1);
            chk("byp_breq", {63'd0, bus_req}, 64'd0);
            chk("byp_rdata", read_data, exp_rdata);
            bus_ack = 1'b1;
            bus_rdata = {$urandom, $urandom};
            if (poke_busy) begin
                start = 1'b1; mem_read = 1'b1; size = 2'd0; address = 64'h0;
            end
            step();
            bus_ack = 1'b0; start = 1'b0; mem_read = 1'b0;
        end else begin
            exp_addr  = {addr[63:3], 3'b000};
            exp_wdata = wdata << (8 * off);
            exp_strb  = wr ? 8'(((1 << bytes) - 1) << off) : 8'h00;
            szmask    = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
            ack_ok    = (ack_at >= 1) && (ack_at <= TMO);
            exp_done_cyc = ack_ok ? ack_at + 1 : TMO + 1;
            cyc = 1;
            while (cyc <= TMO + 10 && !done) begin
                chk("req_breq", {63'd0, bus_req}, 64'd1);
                chk("req_busy", {63'd0, busy}, 64'd1);
                chk("req_bwe", {63'd0, bus_we}, {63'd0, wr});
                chk("req_baddr", bus_addr, exp_addr);
                chk("req_bstrb", {56'd0, bus_wstrb}, {56'd0, exp_strb});
                if (wr) chk("req_bwdat", bus_wdata, exp_wdata);
                if (poke_busy && cyc == 1) begin
                    start = 1'b1; mem_read = ~rd; mem_write = ~wr; size = 2'd0;
                    address = 64'h10;
                end
                bus_ack   = (cyc == ack_at);
                bus_rdata = (cyc == ack_at) ? rdata : {$urandom, $urandom};
                step();
                start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
                cyc++;
            end
            chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
            chk("resp_done", {63'd0, done}, 64'd1);
            chk("resp_err", {63'd0, error}, {63'd0, !ack_ok});
            chk("resp_breq", {63'd0, bus_req}, 64'd0);
            if (rd && ack_ok) exp_rdata = (rdata >> (8 * off)) & szmask;
            chk("resp_rdata", read_data, exp_rdata);
            step();
        end
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_err", {63'd0, error}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_breq", {63'd0, bus_req}, 64'd0);
        chk("idle_rdata", read_data, exp_rdata);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'd0; address = '0; write_data = '0; bus_rdata = '0; bus_ack = 1'b0;
        exp_rdata = '0;
        repeat (3) step();
        chk_all_zero("rst");
        reset = 1'b0;
        step();

        // Byte load, store half in the top lanes, misaligned word, timeout.
        run_txn(1, 0, 2'd0, 64'h1003, 64'h0, 64'h8877665544332211, 1, 0);
        chk("ldurb_val", read_data, 64'h44);
        run_txn(0, 1, 2'd1, 64'h2006, 64'hBEEF, 64'h0, 2, 0);
        run_txn(1, 0, 2'd2, 64'h1002, 64'h0, 64'h0, 1, 0);
        run_txn(1, 0, 2'd3, 64'h3000, 64'h0, 64'hDEAD_BEEF_0000_1111, 0, 0);
        run_txn(1, 0, 2'd2, 64'h4004, 64'h0, 64'hCAFEF00D_12345678, TMO, 0);
        run_txn(1, 1, 2'd0, 64'h5000, 64'h0, 64'h0, 1, 0);
        run_txn(0, 0, 2'd1, 64'h5002, 64'h0, 64'h0, 1, 0);
        run_txn(1, 0, 2'd1, 64'h600A, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 1);

        // Reset during the third cycle of a pending read.
        start = 1'b1; mem_read = 1'b1; size = 2'd3; address = 64'h7000;
        step();
        start = 1'b0; mem_read = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rdata = '0;
        chk_all_zero("midrst");
        step();
        chk("midrst_nodone", {63'd0, done}, 64'd0);
        run_txn(1, 0, 2'd3, 64'h7008, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 2, 0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  ops;
            logic [63:0] a;
            int          ack;
            ops = 2'($urandom_range(0, 9) < 8 ? ($urandom_range(0, 1) ? 2'b01 : 2'b10)
                                              : ($urandom_range(0, 1) ? 2'b11 : 2'b00));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0 || ops == 2'b00) a[2:0] = 3'd0;
            ack = $urandom_range(0, 18);
            run_txn(ops[1], ops[0], 2'($urandom_range(0, 3)), a, {$urandom, $urandom},
                    {$urandom, $urandom}, ack, bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
